// File: rtl/pipe_idex_ctl.sv
// rtl/pipe_idex_ctl.sv - ID/EX pipeline register with hold, flush, load-use bubbles and bubble counter
module pipe_idex_ctl #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               CLR_N,
    input  logic               STALL,
    input  logic               FLUSH,
    input  logic               VALID_D,
    input  logic               RFWE_D,
    input  logic               RFDSEL_D,
    input  logic               DMWE_D,
    input  logic               MTORF_D,
    input  logic               ALUSEL_D,
    input  logic [ALUOP_W-1:0] ALUOP_D,
    input  logic [REG_AW-1:0]  RS_D,
    input  logic [REG_AW-1:0]  RT_D,
    input  logic [REG_AW-1:0]  RD_D,
    input  logic [DATA_W-1:0]  SIMM_D,
    input  logic [DATA_W-1:0]  RFD1_D,
    input  logic [DATA_W-1:0]  RFD2_D,
    output logic               VALID_E,
    output logic               RFWE_E,
    output logic               RFDSEL_E,
    output logic               DMWE_E,
    output logic               MTORF_E,
    output logic               ALUSEL_E,
    output logic [ALUOP_W-1:0] ALUOP_E,
    output logic [REG_AW-1:0]  RS_E,
    output logic [REG_AW-1:0]  RT_E,
    output logic [REG_AW-1:0]  RD_E,
    output logic [DATA_W-1:0]  SIMM_E,
    output logic [DATA_W-1:0]  RFD1_E,
    output logic [DATA_W-1:0]  RFD2_E,
    output logic               LU_HAZ,
    output logic [CNT_W-1:0]   BUBBLE_CNT
);

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2
    } action_t;

    action_t action;
    logic    rt_e_nonzero;
    logic    rt_e_match;

    // A load in EX whose destination is read by the decode instruction needs one bubble.
    assign rt_e_nonzero = (RT_E != '0);
    assign rt_e_match   = (RT_E == RS_D) || (RT_E == RT_D);
    assign LU_HAZ       = VALID_E & MTORF_E & VALID_D & rt_e_nonzero & rt_e_match;

    always_comb begin
        action = ACT_LOAD;
        if (STALL) begin
            action = ACT_HOLD;
        end else if (FLUSH || LU_HAZ) begin
            action = ACT_BUBBLE;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            VALID_E  <= 1'b0;
            RFWE_E   <= 1'b0;
            RFDSEL_E <= 1'b0;
            DMWE_E   <= 1'b0;
            MTORF_E  <= 1'b0;
            ALUSEL_E <= 1'b0;
            ALUOP_E  <= '0;
            RS_E     <= '0;
            RT_E     <= '0;
            RD_E     <= '0;
            SIMM_E   <= '0;
            RFD1_E   <= '0;
            RFD2_E   <= '0;
        end else begin
            case (action)
                ACT_BUBBLE: begin
                    VALID_E  <= 1'b0;
                    RFWE_E   <= 1'b0;
                    RFDSEL_E <= 1'b0;
                    DMWE_E   <= 1'b0;
                    MTORF_E  <= 1'b0;
                    ALUSEL_E <= 1'b0;
                    ALUOP_E  <= '0;
                    RS_E     <= '0;
                    RT_E     <= '0;
                    RD_E     <= '0;
                    SIMM_E   <= '0;
                    RFD1_E   <= '0;
                    RFD2_E   <= '0;
                end
                ACT_LOAD: begin
                    VALID_E  <= VALID_D;
                    // Write enables are gated so an invalid slot can never commit state.
                    RFWE_E   <= RFWE_D & VALID_D;
                    RFDSEL_E <= RFDSEL_D;
                    DMWE_E   <= DMWE_D & VALID_D;
                    MTORF_E  <= MTORF_D;
                    ALUSEL_E <= ALUSEL_D;
                    ALUOP_E  <= ALUOP_D;
                    RS_E     <= RS_D;
                    RT_E     <= RT_D;
                    RD_E     <= RD_D;
                    SIMM_E   <= SIMM_D;
                    RFD1_E   <= RFD1_D;
                    RFD2_E   <= RFD2_D;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            BUBBLE_CNT <= '0;
        end else if ((action == ACT_BUBBLE) && !(&BUBBLE_CNT)) begin
            BUBBLE_CNT <= BUBBLE_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_idex_ctl.sv
// tb/tb_pipe_idex_ctl.sv - directed self-checking bench for pipe_idex_ctl
module tb_pipe_idex_ctl;

    logic        CLK = 1'b0;
    logic        CLR_N;
    logic        STALL, FLUSH, VALID_D;
    logic        RFWE_D, RFDSEL_D, DMWE_D, MTORF_D, ALUSEL_D;
    logic [3:0]  ALUOP_D;
    logic [4:0]  RS_D, RT_D, RD_D;
    logic [31:0] SIMM_D, RFD1_D, RFD2_D;
    logic        VALID_E, RFWE_E, RFDSEL_E, DMWE_E, MTORF_E, ALUSEL_E;
    logic [3:0]  ALUOP_E;
    logic [4:0]  RS_E, RT_E, RD_E;
    logic [31:0] SIMM_E, RFD1_E, RFD2_E;
    logic        LU_HAZ;
    logic [15:0] BUBBLE_CNT;

    logic        s_valid, s_rfwe, s_rfdsel, s_dmwe, s_mtorf, s_alusel;
    logic [3:0]  s_aluop;
    logic [4:0]  s_rs, s_rt, s_rd;
    logic [31:0] s_simm, s_rfd1, s_rfd2;
    logic        s_luhaz;
    logic [1:0]  s_cnt;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    pipe_idex_ctl dut (
        .CLK(CLK), .CLR_N(CLR_N), .STALL(STALL), .FLUSH(FLUSH), .VALID_D(VALID_D),
        .RFWE_D(RFWE_D), .RFDSEL_D(RFDSEL_D), .DMWE_D(DMWE_D), .MTORF_D(MTORF_D),
        .ALUSEL_D(ALUSEL_D), .ALUOP_D(ALUOP_D), .RS_D(RS_D), .RT_D(RT_D), .RD_D(RD_D),
        .SIMM_D(SIMM_D), .RFD1_D(RFD1_D), .RFD2_D(RFD2_D),
        .VALID_E(VALID_E), .RFWE_E(RFWE_E), .RFDSEL_E(RFDSEL_E), .DMWE_E(DMWE_E),
        .MTORF_E(MTORF_E), .ALUSEL_E(ALUSEL_E), .ALUOP_E(ALUOP_E), .RS_E(RS_E),
        .RT_E(RT_E), .RD_E(RD_E), .SIMM_E(SIMM_E), .RFD1_E(RFD1_E), .RFD2_E(RFD2_E),
        .LU_HAZ(LU_HAZ), .BUBBLE_CNT(BUBBLE_CNT)
    );

    pipe_idex_ctl #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .CLR_N(CLR_N), .STALL(STALL), .FLUSH(FLUSH), .VALID_D(VALID_D),
        .RFWE_D(RFWE_D), .RFDSEL_D(RFDSEL_D), .DMWE_D(DMWE_D), .MTORF_D(MTORF_D),
        .ALUSEL_D(ALUSEL_D), .ALUOP_D(ALUOP_D), .RS_D(RS_D), .RT_D(RT_D), .RD_D(RD_D),
        .SIMM_D(SIMM_D), .RFD1_D(RFD1_D), .RFD2_D(RFD2_D),
        .VALID_E(s_valid), .RFWE_E(s_rfwe), .RFDSEL_E(s_rfdsel), .DMWE_E(s_dmwe),
        .MTORF_E(s_mtorf), .ALUSEL_E(s_alusel), .ALUOP_E(s_aluop), .RS_E(s_rs),
        .RT_E(s_rt), .RD_E(s_rd), .SIMM_E(s_simm), .RFD1_E(s_rfd1), .RFD2_E(s_rfd2),
        .LU_HAZ(s_luhaz), .BUBBLE_CNT(s_cnt)
    );

    logic [120:0] e_all;
    assign e_all = {VALID_E, RFWE_E, RFDSEL_E, DMWE_E, MTORF_E, ALUSEL_E, ALUOP_E,
                    RS_E, RT_E, RD_E, SIMM_E, RFD1_E, RFD2_E};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_d(input logic v, input logic mt, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd);
        VALID_D = v; MTORF_D = mt; RS_D = rs; RT_D = rt; RD_D = rd;
    endtask

    initial begin
        CLR_N = 1'b0; STALL = 1'b0; FLUSH = 1'b0;
        VALID_D = 1'b1; RFWE_D = 1'b1; RFDSEL_D = 1'b1; DMWE_D = 1'b1;
        MTORF_D = 1'b0; ALUSEL_D = 1'b1; ALUOP_D = 4'hA;
        RS_D = 5'd3; RT_D = 5'd4; RD_D = 5'd5;
        SIMM_D = 32'hFFFF_FFF0; RFD1_D = 32'h1234_5678; RFD2_D = 32'hCAFE_BABE;
        #2;
        chk("reset_all_zero", 128'(e_all), 128'd0);
        chk("reset_cnt", 128'(BUBBLE_CNT), 128'd0);
        chk("reset_luhaz", 128'(LU_HAZ), 128'd0);
        @(negedge CLK);
        CLR_N = 1'b1;

        step();
        chk("load_rfd1", 128'(RFD1_E), 128'h1234_5678);
        chk("load_rd", 128'(RD_E), 128'd5);
        chk("load_valid", 128'(VALID_E), 128'd1);
        chk("load_rfwe", 128'(RFWE_E), 128'd1);
        chk("load_aluop", 128'(ALUOP_E), 128'hA);
        chk("load_simm", 128'(SIMM_E), 128'hFFFF_FFF0);
        chk("load_rfd2", 128'(RFD2_E), 128'hCAFE_BABE);
        chk("load_luhaz", 128'(LU_HAZ), 128'd0);

        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        chk("flush_all_zero", 128'(e_all), 128'd0);
        chk("flush_cnt", 128'(BUBBLE_CNT), 128'd1);

        drive_d(1'b1, 1'b1, 5'd1, 5'd8, 5'd0);
        step();
        chk("lw_mtorf", 128'(MTORF_E), 128'd1);
        chk("lw_rt", 128'(RT_E), 128'd8);
        drive_d(1'b1, 1'b0, 5'd8, 5'd2, 5'd9);
        #1;
        chk("lu_haz_rs", 128'(LU_HAZ), 128'd1);
        step();
        chk("lu_bubble_valid", 128'(VALID_E), 128'd0);
        chk("lu_bubble_luhaz", 128'(LU_HAZ), 128'd0);
        chk("lu_bubble_cnt", 128'(BUBBLE_CNT), 128'd2);
        step();
        chk("lu_reissue_valid", 128'(VALID_E), 128'd1);
        chk("lu_reissue_rs", 128'(RS_E), 128'd8);

        drive_d(1'b1, 1'b1, 5'd1, 5'd0, 5'd0);
        step();
        drive_d(1'b1, 1'b0, 5'd0, 5'd0, 5'd3);
        #1;
        chk("lu_rt0_luhaz", 128'(LU_HAZ), 128'd0);
        step();
        chk("lu_rt0_cnt", 128'(BUBBLE_CNT), 128'd2);

        drive_d(1'b1, 1'b1, 5'd1, 5'd9, 5'd0);
        step();
        drive_d(1'b1, 1'b0, 5'd9, 5'd4, 5'd6);
        STALL = 1'b1; FLUSH = 1'b1;
        #1;
        chk("stall_luhaz_pre", 128'(LU_HAZ), 128'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_rt", 128'(RT_E), 128'd9);
            chk("stall_mtorf_valid", 128'({MTORF_E, VALID_E}), 128'd3);
            chk("stall_cnt", 128'(BUBBLE_CNT), 128'd2);
            chk("stall_luhaz", 128'(LU_HAZ), 128'd1);
        end
        STALL = 1'b0; FLUSH = 1'b0;
        step();
        chk("stall_release_valid", 128'(VALID_E), 128'd0);
        chk("stall_release_cnt", 128'(BUBBLE_CNT), 128'd3);
        step();
        chk("stall_after_valid", 128'(VALID_E), 128'd1);
        chk("stall_after_cnt", 128'(BUBBLE_CNT), 128'd3);

        VALID_D = 1'b0; RFWE_D = 1'b1; DMWE_D = 1'b1; RD_D = 5'd7; MTORF_D = 1'b0;
        step();
        chk("inv_rfwe", 128'(RFWE_E), 128'd0);
        chk("inv_dmwe", 128'(DMWE_E), 128'd0);
        chk("inv_valid", 128'(VALID_E), 128'd0);
        chk("inv_rd", 128'(RD_E), 128'd7);

        drive_d(1'b1, 1'b0, 5'd3, 5'd4, 5'd5);
        step();
        chk("prereset_valid", 128'(VALID_E), 128'd1);
        #2;
        CLR_N = 1'b0;
        #1;
        chk("async_reset_all_zero", 128'(e_all), 128'd0);
        chk("async_reset_cnt", 128'(BUBBLE_CNT), 128'd0);
        chk("async_reset_sat_cnt", 128'(s_cnt), 128'd0);
        chk("async_reset_luhaz", 128'(LU_HAZ), 128'd0);
        #1;
        CLR_N = 1'b1;

        FLUSH = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("sat_cnt", 128'(s_cnt), 128'((i > 3) ? 3 : i));
            chk("wide_cnt", 128'(BUBBLE_CNT), 128'(i));
        end
        FLUSH = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_idex_ctl.md
# pipe_idex_ctl

Parameterised ID/EX pipeline register for the pipelined MIPS core, sitting between the decode and execute stages. It registers decode-stage control and operands into EX. Beyond a plain flush register, it adds:
- a hold (stall) mode and a valid bit;
- deterministic zero bubbles;
- built-in load-use hazard detection that injects bubbles itself;
- a saturating bubble counter for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, width of the RFD1/RFD2/SIMM datapaths
- REG_AW, 5, register-address width for Rs/Rt/Rd
- ALUOP_W, 4, ALU operation select width
- CNT_W, 16, width of the bubble counter

Ports:
- CLK  in  1  clock; all state updates on rising edge
- CLR_N  in  1  asynchronous, active-low reset; one clock domain, no other reset
- STALL  in  1  hold the EX register contents (downstream freeze)
- FLUSH  in  1  load a bubble instead of the decode-stage instruction
- VALID_D  in  1  decode-stage instruction is real
- RFWE_D, RFDSEL_D, DMWE_D, MTORF_D, ALUSEL_D  in  1 each  decode control bits
- ALUOP_D  in  ALUOP_W  decode ALU op
- RS_D, RT_D, RD_D  in  REG_AW  decode register addresses
- SIMM_D, RFD1_D, RFD2_D  in  DATA_W  sign-extended immediate and register-file read data
- VALID_E, RFWE_E, RFDSEL_E, DMWE_E, MTORF_E, ALUSEL_E  out  1 each  registered EX control
- ALUOP_E  out  ALUOP_W  registered ALU op
- RS_E, RT_E, RD_E  out  REG_AW  registered addresses
- SIMM_E, RFD1_E, RFD2_E  out  DATA_W  registered data
- LU_HAZ  out  1  combinational load-use hazard; the IF/ID stage must hold PC and IF/ID while it is 1
- BUBBLE_CNT  out  CNT_W  saturating count of bubbles loaded

## Operation
- The bubble value is all outputs zero: VALID_E=0, all control bits 0, ALUOP_E=0, addresses 0, data 0. No X values are ever driven.
- LU_HAZ = VALID_E & MTORF_E & VALID_D & (RT_E != 0) & (RT_E == RS_D | RT_E == RT_D).
- Per-edge action is decided by strict priority:
  1. STALL=1: HOLD. All registers keep their values and BUBBLE_CNT is unchanged. A stall overrides flush and hazard, because the EX instruction is older and must not be lost.
  2. FLUSH=1: BUBBLE.
  3. LU_HAZ=1: BUBBLE. The decode instruction stays in ID because upstream is held.
  4. Otherwise: LOAD. Every *_E output takes its *_D input; VALID_E = VALID_D.
- A LOAD with VALID_D=0 stores the D fields as presented. Downstream must gate side effects with VALID_E, and RFWE_E/DMWE_E must be 0 whenever VALID_E=0. To guarantee this, the block ANDs RFWE_D and DMWE_D with VALID_D on load.
- BUBBLE_CNT increments by 1 on every BUBBLE action. It saturates at 2^CNT_W−1 and does not wrap. It is cleared only by reset.
- Reset (CLR_N=0) immediately and asynchronously forces every *_E output to the bubble value and BUBBLE_CNT to 0. LU_HAZ therefore reads 0 during reset, since VALID_E=0.
- Reset deassertion takes effect on the next rising edge. Reset asserted mid-stall or mid-hazard discards the held state.

## Timing
- Latency is one cycle from *_D to *_E on LOAD.
- LU_HAZ is purely combinational from the EX registers and the D inputs, with no register. It lasts exactly one cycle per load-use pair: the bubble clears MTORF_E on the next edge.
- HOLD can last any number of cycles. LU_HAZ may stay asserted throughout a HOLD, and no bubble is counted until the stall releases.
- With FLUSH and LU_HAZ both active in one cycle, a single bubble is loaded and counted once.

## Test plan
- Reset: drive all D inputs nonzero, pulse CLR_N low between edges -> every *_E output and BUBBLE_CNT are 0 immediately, without waiting for an edge.
- Load/flush: load RFD1_D=0x12345678, RD_D=5 -> RFD1_E=0x12345678 and RD_E=5 next cycle. Then FLUSH=1 -> VALID_E=0, all outputs 0, BUBBLE_CNT=1.
- Load-use: EX holds lw with RT_E=8, MTORF_E=1, VALID_E=1; D has RS_D=8 -> LU_HAZ=1; next edge loads a bubble and LU_HAZ drops to 0. Repeat with RT_E=0 -> LU_HAZ=0.
- Stall priority: STALL=1 together with FLUSH=1 and LU_HAZ=1 for 3 cycles -> EX contents unchanged, BUBBLE_CNT unchanged. After release, exactly one bubble is loaded.
- Invalid gating: LOAD with VALID_D=0, RFWE_D=1, DMWE_D=1 -> RFWE_E=0, DMWE_E=0, VALID_E=0.
- Saturation: with CNT_W=2, issue 5 flushes -> BUBBLE_CNT reads 1, 2, 3, 3, 3.
